alu_rr_scheduler: RTL and testbench

//   Shares one ALU datapath between NREQ requesters. Arbitration is round-robin.

---
 rtl/alu_rr_scheduler.sv | 156 +++++++++++++++
 tb/tb_alu_rr_scheduler.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler that shares one ALU among NREQ requesters.
// Each operation is latched, evaluated, and returned with its requester ID on one response channel.
module alu_rr_scheduler #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [3*NREQ-1:0]     req_sel_i,
  input  logic [WIDTH*NREQ-1:0] req_a_i,
  input  logic [WIDTH*NREQ-1:0] req_b_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [IDW-1:0]        rsp_id_o,
  output logic [WIDTH:0]        rsp_o,
  output logic                  rsp_carry_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e           state_q;
  logic [IDW-1:0]   ptr_q;
  logic [2:0]       sel_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IDW-1:0]   id_q;
  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH:0]   rsp_o_q;
  logic             rsp_carry_q;

  logic             gnt_found_s;
  logic [IDW-1:0]   gnt_idx_s;
  logic [IDW-1:0]   cand_s;
  logic             gnt_en_s;
  logic             accept_s;
  logic [IDW-1:0]   ptr_d;
  logic [WIDTH:0]   alu_res_s;

  // Returns {carry, out}; subtraction borrows into the carry bit.
  function automatic logic [WIDTH:0] alu_f(input logic [2:0] sel,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    logic [WIDTH:0] r;
    case (sel)
      3'b000:  r = {1'b0, a & b};
      3'b001:  r = {1'b0, a | b};
      3'b010:  r = {1'b0, a ^ b};
      3'b011:  r = {1'b0, a} + {1'b0, b};
      default: r = {1'b0, a} - {1'b0, b};
    endcase
    return r;
  endfunction

  // Round-robin search for the first valid requester at or above the pointer.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    cand_s      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = IDW'((int'(ptr_q) + k) % NREQ);
      if (!gnt_found_s && req_valid_i[cand_s]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = cand_s;
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  // A grant may be issued from IDLE, or from RESP as the response drains.
  always_comb begin
    gnt_en_s = 1'b0;
    if (state_q == S_IDLE) begin
      gnt_en_s = 1'b1;
    end else if (state_q == S_RESP) begin
      gnt_en_s = rsp_ready_i;
    end else begin
      gnt_en_s = 1'b0;
    end
    accept_s  = gnt_en_s & gnt_found_s;
    ptr_d     = (gnt_idx_s == IDW'(NREQ - 1)) ? '0 : gnt_idx_s + IDW'(1);
    alu_res_s = alu_f(sel_q, a_q, b_q);
  end

  // Ready is forced low while reset is asserted so no handshake can complete.
  always_comb begin
    req_ready_o = '0;
    if (accept_s && rst_n) begin
      req_ready_o[gnt_idx_s] = 1'b1;
    end else begin
      req_ready_o = '0;
    end
  end

  // Scheduler FSM, operand capture and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      sel_q       <= 3'b000;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_o_q     <= '0;
      rsp_carry_q <= 1'b0;
    end else begin
      if (accept_s) begin
        sel_q <= req_sel_i[3*int'(gnt_idx_s) +: 3];
        a_q   <= req_a_i[WIDTH*int'(gnt_idx_s) +: WIDTH];
        b_q   <= req_b_i[WIDTH*int'(gnt_idx_s) +: WIDTH];
        id_q  <= gnt_idx_s;
        ptr_q <= ptr_d;
      end
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_o_q     <= {1'b0, alu_res_s[WIDTH-1:0]};
          rsp_carry_q <= alu_res_s[WIDTH];
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= accept_s ? S_EXEC : S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_o       = rsp_o_q;
  assign rsp_carry_o = rsp_carry_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level reference model.
module tb_alu_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [11:0] req_sel;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [4:0]  rsp_o;
  logic        rsp_carry;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_ptr, m_id, m_o, m_c, p_id, p_o, p_c, last_acc;
  bit m_has_op, m_rsp_valid;
  int dut_grants[$];

  always #5 clk = ~clk;

  alu_rr_scheduler #(.WIDTH(4), .NREQ(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_sel_i(req_sel), .req_a_i(req_a), .req_b_i(req_b),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id), .rsp_o(rsp_o), .rsp_carry_o(rsp_carry)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s got=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic ref_alu(input int sel, input int a, input int b, output int o, output int c);
    case (sel)
      0: begin o = a & b; c = 0; end
      1: begin o = a | b; c = 0; end
      2: begin o = a ^ b; c = 0; end
      3: begin o = (a + b) % 16; c = (a + b > 15) ? 1 : 0; end
      default: begin o = (a - b + 16) % 16; c = (a < b) ? 1 : 0; end
    endcase
  endtask

  function automatic int ref_grant();
    for (int k = 0; k < 4; k++) begin
      if (req_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_id = 0; m_o = 0; m_c = 0;
    m_has_op = 0; m_rsp_valid = 0; last_acc = -1;
  endtask

  // Checks the current cycle, advances one clock, updates the model; returns at negedge.
  task automatic run_cycle();
    int g, o, c;
    bit acc;
    #1;
    g   = ref_grant();
    acc = !m_has_op && (!m_rsp_valid || rsp_ready) && (g >= 0);
    chk("req_ready", {28'd0, req_ready}, acc ? (32'd1 << g) : 32'd0);
    chk("rsp_valid", {31'd0, rsp_valid}, m_rsp_valid);
    chk("rsp_id", {30'd0, rsp_id}, m_id);
    chk("rsp_o", {27'd0, rsp_o}, m_o);
    chk("rsp_carry", {31'd0, rsp_carry}, m_c);
    for (int i = 0; i < 4; i++) if (req_ready[i]) dut_grants.push_back(i);
    @(posedge clk);
    if (m_rsp_valid && rsp_ready) m_rsp_valid = 0;
    if (m_has_op) begin
      m_rsp_valid = 1; m_id = p_id; m_o = p_o; m_c = p_c; m_has_op = 0;
    end
    last_acc = -1;
    if (acc) begin
      ref_alu(req_sel[3*g +: 3], req_a[4*g +: 4], req_b[4*g +: 4], o, c);
      p_o = o; p_c = c; p_id = g; m_has_op = 1;
      m_ptr = (g + 1) % 4; last_acc = g;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_op(input int r, input int sel, input int a, input int b);
    req_sel[3*r +: 3] = sel[2:0];
    req_a[4*r +: 4]   = a[3:0];
    req_b[4*r +: 4]   = b[3:0];
  endtask

  // Single requester operation; response is inspected while held, then drained.
  task automatic directed_op(input int r, input int sel, input int a, input int b,
                             input int exp_o, input int exp_c, input string tag);
    set_op(r, sel, a, b);
    req_valid = 4'd1 << r;
    rsp_ready = 1'b0;
    run_cycle();
    req_valid = 4'd0;
    run_cycle();
    #1;
    chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_id"}, {30'd0, rsp_id}, r);
    chk({tag, "_o"}, {27'd0, rsp_o}, exp_o);
    chk({tag, "_carry"}, {31'd0, rsp_carry}, exp_c);
    rsp_ready = 1'b1;
    run_cycle();
    run_cycle();
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 4'd0; req_sel = 12'd0; req_a = 16'd0; req_b = 16'd0;
    rsp_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    req_valid = 4'hF;
    #1;
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_o", {27'd0, rsp_o}, 32'd0);
    req_valid = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;

    // ALU cases with hand-computed results
    directed_op(0, 3, 9, 8, 5'b00001, 1, "t1_add");
    directed_op(2, 4, 3, 5, 5'b01110, 1, "t2_sub");
    directed_op(2, 7, 7, 2, 5'b00101, 0, "t2_sub7");
    directed_op(0, 0, 12, 10, 5'b01000, 0, "t6_and");

    // all requesters continuously valid: strict rotation
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, i, i + 3, 2 * i);
    req_valid = 4'hF; rsp_ready = 1'b1;
    dut_grants.delete();
    repeat (12) run_cycle();
    for (int k = 0; k < 6; k++) begin
      if (k < dut_grants.size()) chk("t3_order", dut_grants[k], k % 4);
      else chk("t3_order_missing", dut_grants.size(), 6);
    end

    // response stall with requests pending
    do_reset();
    rsp_ready = 1'b1;
    run_cycle();
    run_cycle();
    rsp_ready = 1'b0;
    repeat (5) run_cycle();
    #1;
    chk("t4_stall_ready", {28'd0, req_ready}, 32'd0);
    chk("t4_stall_valid", {31'd0, rsp_valid}, 32'd1);
    rsp_ready = 1'b1;
    #1;
    chk("t4_release_grant", {28'd0, req_ready}, 32'b0010);
    run_cycle();

    // reset while req1 executes
    do_reset();
    req_valid = 4'b0010; set_op(1, 3, 15, 15);
    run_cycle();
    req_valid = 4'b1010;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_rst_ready", {28'd0, req_ready}, 32'd0);
    chk("t5_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("t5_rst_id", {30'd0, rsp_id}, 32'd0);
    chk("t5_rst_o", {27'd0, rsp_o}, 32'd0);
    chk("t5_rst_carry", {31'd0, rsp_carry}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t5_grant1", {28'd0, req_ready}, 32'b0010);
    run_cycle();
    req_valid = 4'd0;
    repeat (4) run_cycle();

    // randomized traffic with random response backpressure
    do_reset();
    req_valid = 4'd0;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && last_acc == i) begin
          req_valid[i] = 1'b0;
        end else if (!req_valid[i] && ($urandom % 3) == 0) begin
          set_op(i, $urandom % 8, $urandom % 16, $urandom % 16);
          req_valid[i] = 1'b1;
        end else if (req_valid[i] && ($urandom % 20) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom % 2) == 0;
      run_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
